// File: rtl/reg_bus_master_pkg.sv
// Shared definitions for the register-bus master: command opcodes and FSM states.
package reg_bus_master_pkg;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_RMW = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

endpackage

// File: rtl/reg_bus_master_if.sv
// Command, response and register-bus signals of the master, bundled with
// a master modport (the design) and a slave modport (whoever drives it).
interface reg_bus_master_if #(
    parameter int AW = 2,
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] cmd_mask;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    logic [AW-1:0] bus_addr;
    logic          bus_wr;
    logic          bus_sel;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
        input  rsp_ready, bus_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output bus_addr, bus_wr, bus_sel, bus_wdata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
        output rsp_ready, bus_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  bus_addr, bus_wr, bus_sel, bus_wdata
    );

endinterface

// File: rtl/reg_bus_master.sv
// Register-bus master: turns write / read / read-modify-write commands into
// single-cycle bus transfers and returns one response per command.
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    reg_bus_master_if.master    bus,
    output logic [7:0]          txn_count
);

    state_t        state, state_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic [DW-1:0] mask_q, mask_n;
    logic [DW-1:0] old_q, old_n;
    logic [7:0]    count_n;

    logic          rsp_valid_n, rsp_err_n;
    logic [DW-1:0] rsp_data_n;
    logic [AW-1:0] bus_addr_n;
    logic          bus_wr_n, bus_sel_n;
    logic [DW-1:0] bus_wdata_n;

    assign bus.cmd_ready = (state == IDLE);

    // Every output is registered, so the next-state logic also computes the
    // value each output takes in the cycle after the edge.
    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        mask_n      = mask_q;
        old_n       = old_q;
        count_n     = txn_count;
        rsp_valid_n = bus.rsp_valid;
        rsp_err_n   = bus.rsp_err;
        rsp_data_n  = bus.rsp_data;
        bus_addr_n  = bus.bus_addr;
        bus_wr_n    = 1'b0;
        bus_sel_n   = 1'b0;
        bus_wdata_n = '0;

        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_n  = bus.cmd_addr;
                    wdata_n = bus.cmd_wdata;
                    mask_n  = bus.cmd_mask;
                    case (bus.cmd_op)
                        OP_WR: begin
                            state_n     = WR;
                            bus_sel_n   = 1'b1;
                            bus_wr_n    = 1'b1;
                            bus_addr_n  = bus.cmd_addr;
                            bus_wdata_n = bus.cmd_wdata;
                        end
                        OP_RD: begin
                            state_n    = RD;
                            bus_sel_n  = 1'b1;
                            bus_addr_n = bus.cmd_addr;
                        end
                        OP_RMW: begin
                            state_n    = RMW_RD;
                            bus_sel_n  = 1'b1;
                            bus_addr_n = bus.cmd_addr;
                        end
                        default: begin
                            state_n     = RESP;
                            rsp_valid_n = 1'b1;
                            rsp_err_n   = 1'b1;
                            rsp_data_n  = '0;
                        end
                    endcase
                end
            end
            WR: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = '0;
            end
            RD: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = bus.bus_rdata;
            end
            RMW_RD: begin
                // The responder reads combinationally, so the merge can use
                // bus_rdata directly and the write follows with no gap.
                state_n     = RMW_WR;
                old_n       = bus.bus_rdata;
                bus_sel_n   = 1'b1;
                bus_wr_n    = 1'b1;
                bus_addr_n  = addr_q;
                bus_wdata_n = (bus.bus_rdata & ~mask_q) | (wdata_q & mask_q);
            end
            RMW_WR: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = old_q;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    count_n     = txn_count + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset abandons any transfer in flight: the state and all outputs clear
    // together, so no further bus cycle or response can follow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            mask_q        <= '0;
            old_q         <= '0;
            txn_count     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
            bus.bus_addr  <= '0;
            bus.bus_wr    <= 1'b0;
            bus.bus_sel   <= 1'b0;
            bus.bus_wdata <= '0;
        end else begin
            state         <= state_n;
            addr_q        <= addr_n;
            wdata_q       <= wdata_n;
            mask_q        <= mask_n;
            old_q         <= old_n;
            txn_count     <= count_n;
            bus.rsp_valid <= rsp_valid_n;
            bus.rsp_err   <= rsp_err_n;
            bus.rsp_data  <= rsp_data_n;
            bus.bus_addr  <= bus_addr_n;
            bus.bus_wr    <= bus_wr_n;
            bus.bus_sel   <= bus_sel_n;
            bus.bus_wdata <= bus_wdata_n;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master against a four-entry register file
// that answers reads combinationally.
module tb_reg_bus_master;
    import reg_bus_master_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] mask;
        logic [15:0] expData;
        logic        expErr;
        int          expLat;
        int          expBus;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] txnCount;
    logic [15:0] mem [0:3];
    int         busCycles;
    int         busWrites;
    int         total;
    int         bad;
    vec_t       vecs [12];

    reg_bus_master_if #(.AW(2), .DW(16)) ifc ();

    reg_bus_master #(.AW(2), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc.master),
        .txn_count (txnCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ifc.bus_rdata = mem[ifc.bus_addr];

    always @(posedge clk) begin
        if (ifc.bus_sel && ifc.bus_wr) mem[ifc.bus_addr] <= ifc.bus_wdata;
    end

    always @(posedge clk) begin
        if (ifc.bus_sel) busCycles <= busCycles + 1;
        if (ifc.bus_sel && ifc.bus_wr) busWrites <= busWrites + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Offers one command and returns #1 after the accept edge with the
    // command fields scrambled, since they must be ignored from then on.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] mask);
        int guard;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_addr  = addr;
        ifc.cmd_wdata = wdata;
        ifc.cmd_mask  = mask;
        guard = 0;
        while (!ifc.cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("cmd_ready before accept", {31'd0, ifc.cmd_ready}, 32'd1);
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = OP_RSV;
        ifc.cmd_addr  = 2'($urandom);
        ifc.cmd_wdata = 16'($urandom);
        ifc.cmd_mask  = 16'($urandom);
    endtask

    task automatic waitRsp(output int lat);
        lat = 1;
        while (!ifc.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finishRsp(input string name);
        ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifc.rsp_ready = 1'b0;
        checkOutput({name, " rsp_valid drop"}, {31'd0, ifc.rsp_valid}, 32'd0);
    endtask

    task automatic runCmd(input string name, input logic [1:0] op, input logic [1:0] addr,
                          input logic [15:0] wdata, input logic [15:0] mask,
                          input logic [15:0] expData, input logic expErr,
                          input int expLat, input int expBus);
        int lat;
        int busBefore;
        busBefore = busCycles;
        applyStimulus(op, addr, wdata, mask);
        waitRsp(lat);
        checkOutput({name, " latency"}, lat, expLat);
        checkOutput({name, " rsp_data"}, {16'd0, ifc.rsp_data}, {16'd0, expData});
        checkOutput({name, " rsp_err"}, {31'd0, ifc.rsp_err}, {31'd0, expErr});
        finishRsp(name);
        checkOutput({name, " bus cycles"}, busCycles - busBefore, expBus);
    endtask

    initial begin
        int lat;
        int writesBefore;
        total = 0;
        bad = 0;
        busCycles = 0;
        busWrites = 0;
        rst = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = OP_WR;
        ifc.cmd_addr  = '0;
        ifc.cmd_wdata = '0;
        ifc.cmd_mask  = '0;
        ifc.rsp_ready = 1'b0;

        vecs[0]  = '{OP_WR,  2'd2, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 2, 1};
        vecs[1]  = '{OP_RD,  2'd2, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 2, 1};
        vecs[2]  = '{OP_WR,  2'd1, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 2, 1};
        vecs[3]  = '{OP_RMW, 2'd1, 16'hAB00, 16'hFF00, 16'h00FF, 1'b0, 3, 2};
        vecs[4]  = '{OP_RD,  2'd1, 16'h0000, 16'h0000, 16'hABFF, 1'b0, 2, 1};
        vecs[5]  = '{OP_RSV, 2'd0, 16'h1234, 16'hFFFF, 16'h0000, 1'b1, 1, 0};
        vecs[6]  = '{OP_WR,  2'd3, 16'hF0F0, 16'h0000, 16'h0000, 1'b0, 2, 1};
        vecs[7]  = '{OP_RMW, 2'd3, 16'h0F0F, 16'h00FF, 16'hF0F0, 1'b0, 3, 2};
        vecs[8]  = '{OP_RD,  2'd3, 16'h0000, 16'h0000, 16'hF00F, 1'b0, 2, 1};
        vecs[9]  = '{OP_RD,  2'd2, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 2, 1};
        vecs[10] = '{OP_WR,  2'd0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 2, 1};
        vecs[11] = '{OP_RD,  2'd0, 16'h0000, 16'h0000, 16'h1234, 1'b0, 2, 1};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset cmd_ready", {31'd0, ifc.cmd_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
        checkOutput("reset rsp_err", {31'd0, ifc.rsp_err}, 32'd0);
        checkOutput("reset rsp_data", {16'd0, ifc.rsp_data}, 32'd0);
        checkOutput("reset bus_sel", {31'd0, ifc.bus_sel}, 32'd0);
        checkOutput("reset bus_wr", {31'd0, ifc.bus_wr}, 32'd0);
        checkOutput("reset bus_addr", {30'd0, ifc.bus_addr}, 32'd0);
        checkOutput("reset bus_wdata", {16'd0, ifc.bus_wdata}, 32'd0);
        checkOutput("reset txn_count", {24'd0, txnCount}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            runCmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                   vecs[i].mask, vecs[i].expData, vecs[i].expErr, vecs[i].expLat,
                   vecs[i].expBus);
        end
        checkOutput("txn_count after table", {24'd0, txnCount}, 32'd12);

        // Response held off for five cycles must stay put and block commands.
        applyStimulus(OP_RD, 2'd2, 16'h0000, 16'h0000);
        waitRsp(lat);
        checkOutput("stall latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("stall%0d rsp_valid", i), {31'd0, ifc.rsp_valid}, 32'd1);
            checkOutput($sformatf("stall%0d rsp_data", i), {16'd0, ifc.rsp_data}, 32'h0000BEEF);
            checkOutput($sformatf("stall%0d cmd_ready", i), {31'd0, ifc.cmd_ready}, 32'd0);
        end
        finishRsp("stall");
        checkOutput("txn_count after stall", {24'd0, txnCount}, 32'd13);

        // Reset while the RMW read is on the bus: no write may follow.
        runCmd("pre-rmw write", OP_WR, 2'd0, 16'h5555, 16'h0000, 16'h0000, 1'b0, 2, 1);
        writesBefore = busWrites;
        applyStimulus(OP_RMW, 2'd0, 16'hFFFF, 16'hFFFF);
        checkOutput("rmw_rd bus_sel", {31'd0, ifc.bus_sel}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort bus_sel", {31'd0, ifc.bus_sel}, 32'd0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort bus writes", busWrites - writesBefore, 0);
        checkOutput("abort rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
        checkOutput("abort txn_count", {24'd0, txnCount}, 32'd0);
        runCmd("post-abort read", OP_RD, 2'd0, 16'h0000, 16'h0000, 16'h5555, 1'b0, 2, 1);
        checkOutput("txn_count after abort", {24'd0, txnCount}, 32'd1);

        // 255 more reads bring the counter to 256 responses, wrapping to 0.
        for (int i = 0; i < 255; i++) begin
            runCmd($sformatf("wrap%0d", i), OP_RD, 2'd0, 16'h0000, 16'h0000,
                   16'h5555, 1'b0, 2, 1);
            if (i == 253) checkOutput("txn_count at 255", {24'd0, txnCount}, 32'd255);
        end
        checkOutput("txn_count wrap", {24'd0, txnCount}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
